// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: XLEN default, RV32 opcode constants, FSM state enum and supported-opcode check shared by alu_arbiter
package alu_arbiter_pkg;
  localparam int XLEN_DEF = 32;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
  function automatic logic op_supported(input logic [6:0] op);
    return op inside {OP_R, OP_IMM, OP_LOAD, OP_STORE};
  endfunction
endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: per-requester req/rsp handshakes plus shared-ALU drive/return; slave = arbiter side, master = requesters and ALU
interface alu_arbiter_if #(parameter int XLEN = 32);
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [1:0][6:0] req_opcode;
  logic [1:0][2:0] req_funct3;
  logic [1:0][6:0] req_funct7;
  logic [1:0][XLEN-1:0] req_rs1;
  logic [1:0][XLEN-1:0] req_rs2;
  logic [1:0][XLEN-1:0] req_imm;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready;
  logic [XLEN-1:0] rsp_result;
  logic rsp_non_zero;
  logic rsp_err;
  logic [6:0] alu_opcode;
  logic [2:0] alu_funct3;
  logic [6:0] alu_funct7;
  logic [XLEN-1:0] alu_rs1;
  logic [XLEN-1:0] alu_rs2;
  logic [XLEN-1:0] alu_imm;
  logic [XLEN-1:0] alu_result_in;
  logic alu_non_zero_in;
  modport slave (
    input req_valid, req_opcode, req_funct3, req_funct7, req_rs1, req_rs2, req_imm,
    input rsp_ready, alu_result_in, alu_non_zero_in,
    output req_ready, rsp_valid, rsp_result, rsp_non_zero, rsp_err,
    output alu_opcode, alu_funct3, alu_funct7, alu_rs1, alu_rs2, alu_imm
  );
  modport master (
    output req_valid, req_opcode, req_funct3, req_funct7, req_rs1, req_rs2, req_imm,
    output rsp_ready, alu_result_in, alu_non_zero_in,
    input req_ready, rsp_valid, rsp_result, rsp_non_zero, rsp_err,
    input alu_opcode, alu_funct3, alu_funct7, alu_rs1, alu_rs2, alu_imm
  );
endinterface

// File: rtl/alu_arbiter_grant.sv
// alu_arbiter_grant: one-hot 2-way grant from valid (in: valid[1:0], last when ALU_ARBITER_RR_EN; out: grant[1:0]); fixed priority to 0 unless ALU_ARBITER_RR_EN
module alu_arbiter_grant (
  input logic [1:0] valid,
`ifdef ALU_ARBITER_RR_EN
  input logic last,
`endif
  output logic [1:0] grant
);
`ifdef ALU_ARBITER_RR_EN
  always_comb grant = &valid ? (last ? 2'b01 : 2'b10) : valid;
`else
  always_comb grant = valid[0] ? 2'b01 : valid;
`endif
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: IDLE/EXEC/RESP sequencer sharing one ALU between two requesters (ports: clk, rst sync active-high, bus alu_arbiter_if.slave); ALU_ARBITER_RR_EN enables round-robin
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input logic clk,
  input logic rst,
  alu_arbiter_if.slave bus
);
  state_e state;
  logic [1:0] grant;
  logic sel;
  logic gnt_q;
  logic ok;
  logic [XLEN-1:0] res_sel;
`ifdef ALU_ARBITER_RR_EN
  logic last;
  alu_arbiter_grant u_grant (.valid(bus.req_valid), .last(last), .grant(grant));
`else
  alu_arbiter_grant u_grant (.valid(bus.req_valid), .grant(grant));
`endif
  assign sel = grant[1];
  assign ok = op_supported(bus.alu_opcode);
  assign res_sel = ok ? bus.alu_result_in : '0;
  assign bus.req_ready = (state == IDLE && !rst) ? grant : 2'b00;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt_q <= 1'b0;
      bus.rsp_valid <= 2'b00;
      bus.rsp_result <= '0;
      bus.rsp_non_zero <= 1'b0;
      bus.rsp_err <= 1'b0;
      bus.alu_opcode <= '0;
      bus.alu_funct3 <= '0;
      bus.alu_funct7 <= '0;
      bus.alu_rs1 <= '0;
      bus.alu_rs2 <= '0;
      bus.alu_imm <= '0;
`ifdef ALU_ARBITER_RR_EN
      last <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: if (|bus.req_valid) begin
          bus.alu_opcode <= bus.req_opcode[sel];
          bus.alu_funct3 <= bus.req_funct3[sel];
          bus.alu_funct7 <= bus.req_funct7[sel];
          bus.alu_rs1 <= bus.req_rs1[sel];
          bus.alu_rs2 <= bus.req_rs2[sel];
          bus.alu_imm <= bus.req_imm[sel];
          gnt_q <= sel;
`ifdef ALU_ARBITER_RR_EN
          last <= sel;
`endif
          state <= EXEC;
        end
        EXEC: begin
          bus.rsp_result <= res_sel;
          bus.rsp_non_zero <= ok && bus.alu_non_zero_in;
          bus.rsp_err <= !ok;
          bus.rsp_valid <= 2'b01 << gnt_q;
          state <= RESP;
        end
        RESP: if (bus.rsp_ready[gnt_q]) begin
          bus.rsp_valid <= 2'b00;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scoreboard bench for alu_arbiter with a behavioural shared ALU
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;
  typedef struct {
    int idx;
    logic [31:0] res;
    logic nz;
    logic err;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  exp_t sbq[$];
  exp_t mon_e;
  int checks = 0;
  int failures = 0;
  int seq[4];
  always #5 clk = ~clk;
  alu_arbiter_if #(.XLEN(32)) bus ();
  alu_arbiter #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always_comb begin
    case (bus.alu_opcode)
      OP_R: bus.alu_result_in = bus.alu_funct7[5] ? bus.alu_rs1 - bus.alu_rs2 : bus.alu_rs1 + bus.alu_rs2;
      OP_IMM, OP_LOAD, OP_STORE: bus.alu_result_in = bus.alu_rs1 + bus.alu_imm;
      default: bus.alu_result_in = 32'hDEADBEEF;
    endcase
    bus.alu_non_zero_in = op_supported(bus.alu_opcode) ? (bus.alu_result_in != 0) : 1'b1;
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst) sbq.delete();
    else if (|bus.rsp_valid) begin
      if (sbq.size() == 0) chk("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
      else begin
        mon_e = sbq[0];
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(2'b01 << mon_e.idx));
        chk("rsp_result", 64'(bus.rsp_result), 64'(mon_e.res));
        chk("rsp_non_zero", 64'(bus.rsp_non_zero), 64'(mon_e.nz));
        chk("rsp_err", 64'(bus.rsp_err), 64'(mon_e.err));
        if (bus.rsp_ready[mon_e.idx]) void'(sbq.pop_front());
      end
    end
  end
  task automatic set_req(input int i, input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    bus.req_opcode[i] = op;
    bus.req_funct7[i] = f7;
    bus.req_funct3[i] = f3;
    bus.req_rs1[i] = a;
    bus.req_rs2[i] = b;
    bus.req_imm[i] = imm;
  endtask
  task automatic accept(input int i, input logic [31:0] r, input logic nz, input logic err, input string name);
    int n = 0;
    @(negedge clk);
    while (bus.req_ready == 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_grant"}, 64'(bus.req_ready), 64'(2'b01 << i));
    if (bus.req_ready == (2'b01 << i)) sbq.push_back('{idx: i, res: r, nz: nz, err: err});
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input int i, input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                       input logic [31:0] r, input logic nz, input logic err, input string name);
    set_req(i, op, f7, f3, a, b, imm);
    bus.req_valid[i] = 1'b1;
    accept(i, r, nz, err, name);
    bus.req_valid[i] = 1'b0;
    bus.req_rs1[i] = $urandom;
    bus.req_imm[i] = $urandom;
    bus.req_opcode[i] = 7'b1111111;
  endtask
  task automatic wait_idle(input string name);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (sbq.size() == 0 && bus.rsp_valid == 2'b00) break;
    end
    chk({name, "_drain"}, 64'(sbq.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
`ifdef ALU_ARBITER_RR_EN
    seq = '{0, 1, 0, 1};
`else
    seq = '{0, 0, 0, 0};
`endif
    rst = 1'b1;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b11;
    for (int i = 0; i < 2; i++) set_req(i, 7'd0, 7'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_result", 64'(bus.rsp_result), 64'd0);
    chk("rst_rsp_non_zero", 64'(bus.rsp_non_zero), 64'd0);
    chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
    chk("rst_alu_opcode", 64'(bus.alu_opcode), 64'd0);
    chk("rst_alu_rs1", 64'(bus.alu_rs1), 64'd0);
    chk("rst_alu_imm", 64'(bus.alu_imm), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    issue(0, OP_IMM, 7'd0, 3'd0, 32'd5, 32'd0, 32'd7, 32'd12, 1'b1, 1'b0, "addi");
    @(negedge clk);
    chk("lat_exec_valid", 64'(bus.rsp_valid), 64'd0);
    chk("lat_exec_ready", 64'(bus.req_ready), 64'd0);
    chk("alu_rs1_latched", 64'(bus.alu_rs1), 64'd5);
    @(negedge clk);
    chk("lat_resp_valid", 64'(bus.rsp_valid), 64'b01);
    @(posedge clk);
    #1;
    wait_idle("addi");
    issue(0, OP_LOAD, 7'd0, 3'd2, 32'd100, 32'd0, 32'hFFFFFFFC, 32'd96, 1'b1, 1'b0, "load");
    wait_idle("load");
    issue(1, OP_STORE, 7'd0, 3'd2, 32'd8, 32'd55, 32'hFFFFFFF8, 32'd0, 1'b0, 1'b0, "store");
    wait_idle("store");
    issue(1, OP_R, 7'd0, 3'd0, 32'h7FFFFFFF, 32'd1, 32'd0, 32'h80000000, 1'b1, 1'b0, "add");
    wait_idle("add");
    issue(0, 7'b1100011, 7'd0, 3'd0, 32'd1, 32'd2, 32'd3, 32'd0, 1'b0, 1'b1, "branch");
    wait_idle("branch");
    chk("branch_idle", 64'(dut.state), 64'(IDLE));
    bus.rsp_ready = 2'b01;
    issue(1, OP_R, 7'b0100000, 3'd0, 32'd9, 32'd9, 32'd0, 32'd0, 1'b0, 1'b0, "sub");
    set_req(0, OP_IMM, 7'd0, 3'd0, 32'd3, 32'd0, 32'd4);
    bus.req_valid[0] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_no_accept", 64'(bus.req_ready), 64'd0);
    end
    @(posedge clk);
    #1 bus.rsp_ready = 2'b11;
    accept(0, 32'd7, 1'b1, 1'b0, "after_stall");
    bus.req_valid[0] = 1'b0;
    wait_idle("after_stall");
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    set_req(0, OP_IMM, 7'd0, 3'd0, 32'd1, 32'd0, 32'd1);
    set_req(1, OP_R, 7'd0, 3'd0, 32'd3, 32'd4, 32'd0);
    bus.req_valid = 2'b11;
    for (int k = 0; k < 4; k++)
      accept(seq[k], seq[k] == 0 ? 32'd2 : 32'd7, 1'b1, 1'b0, "tie");
    bus.req_valid = 2'b00;
    wait_idle("tie");
    bus.rsp_ready = 2'b00;
    issue(0, OP_IMM, 7'd0, 3'd0, 32'd10, 32'd0, 32'd20, 32'd30, 1'b1, 1'b0, "pre_rst");
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_valid", 64'(bus.rsp_valid), 64'b01);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("in_rst_req_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    chk("post_rst_valid", 64'(bus.rsp_valid), 64'd0);
    chk("post_rst_state", 64'(dut.state), 64'(IDLE));
    chk("post_rst_alu_opcode", 64'(bus.alu_opcode), 64'd0);
    chk("post_rst_alu_rs1", 64'(bus.alu_rs1), 64'd0);
    chk("post_rst_alu_imm", 64'(bus.alu_imm), 64'd0);
    chk("post_rst_result", 64'(bus.rsp_result), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    bus.rsp_ready = 2'b11;
    set_req(0, OP_IMM, 7'd0, 3'd0, 32'd1, 32'd0, 32'd1);
    set_req(1, OP_R, 7'd0, 3'd0, 32'd3, 32'd4, 32'd0);
    bus.req_valid = 2'b11;
    accept(0, 32'd2, 1'b1, 1'b0, "post_rst_tie");
    bus.req_valid = 2'b00;
    wait_idle("post_rst_tie");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
